// File: rtl/vpu_pkg.sv
// Shared VPU definitions: hit word layout, sprite table entry layout,
// register map constants and the hit word pack helper.
package vpu_pkg;

  localparam int NUM_LEVELS  = 32;
  localparam int SLOTS       = 4;
  localparam int SPRITE_SIZE = 16;

  localparam int HIT_W       = 23;
  localparam int HIT_LVL_LSB = 18;
  localparam int HIT_ID_LSB  = 9;
  localparam int HIT_OX_LSB  = 5;
  localparam int HIT_OY_LSB  = 1;
  localparam int HIT_VLD_BIT = 0;

  localparam int ENT_W = 30;

  localparam logic [7:0] ADDR_STATUS = 8'd32;

  // [29] enable, [28:19] x, [18:9] y, [8:0] id
  typedef struct packed {
    logic       en;
    logic [9:0] x;
    logic [9:0] y;
    logic [8:0] id;
  } entry_t;

  typedef struct packed {
    logic       vld;
    logic [4:0] lvl;
    logic [8:0] id;
    logic [9:0] x;
    logic [3:0] row;
  } slot_t;

  function automatic logic [HIT_W-1:0] hit_pack(
    input logic [4:0] lvl,
    input logic [8:0] id,
    input logic [3:0] ox,
    input logic [3:0] oy
  );
    logic [HIT_W-1:0] w;
    w = '0;
    w[HIT_LVL_LSB +: 5] = lvl;
    w[HIT_ID_LSB  +: 9] = id;
    w[HIT_OX_LSB  +: 4] = ox;
    w[HIT_OY_LSB  +: 4] = oy;
    w[HIT_VLD_BIT]      = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/sprite_line_scanner.sv
// Line scan FSM: walks the sprite table from level 31 down to 0, fills a
// shadow slot set, then commits it to the active set used by the pixel path.
// Ports: i_new_line/i_line_y start a scan, o_idx addresses the table,
// i_entry is the entry at o_idx, o_slots/o_overflow are the committed set,
// o_busy is high in SCAN/COMMIT, o_ovf_event pulses on an overflowing commit.
module sprite_line_scanner
  import vpu_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_new_line,
  input  logic [9:0]             i_line_y,
  input  entry_t                 i_entry,
  output logic [4:0]             o_idx,
  output logic                   o_busy,
  output slot_t [SLOTS-1:0]      o_slots,
  output logic                   o_overflow,
  output logic                   o_ovf_event
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_COMMIT
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_commit;
  logic [9:0]        r_line_y;
  logic [4:0]        r_idx;
  logic [2:0]        r_cnt;
  slot_t [SLOTS-1:0] r_shadow;
  logic              r_sh_ovf;
  slot_t [SLOTS-1:0] r_active;
  logic              r_ovf;
  logic [9:0]        w_diff;
  logic              w_cand;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // A new_line in any state restarts; a restart in COMMIT skips the commit.
  always_comb begin
    w_next   = r_state;
    w_commit = 1'b0;
    unique case (r_state)
      S_IDLE:   w_next = S_IDLE;
      S_SCAN:   if (r_idx == 5'd0) w_next = S_COMMIT;
      S_COMMIT: begin
        w_next   = S_IDLE;
        w_commit = 1'b1;
      end
      default:  w_next = S_IDLE;
    endcase
    if (i_new_line) begin
      w_next   = S_SCAN;
      w_commit = 1'b0;
    end
  end

  // Row distance wraps mod 1024; a hit is any distance below 16.
  assign w_diff = r_line_y - i_entry.y;
  assign w_cand = (r_state == S_SCAN) && i_entry.en &&
                  (i_entry.id != 9'd0) && (w_diff[9:4] == 6'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_line_y <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_sh_ovf <= 1'b0;
      r_active <= '0;
      r_ovf    <= 1'b0;
    end else if (i_new_line) begin
      r_line_y <= i_line_y;
      r_idx    <= 5'd31;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_sh_ovf <= 1'b0;
    end else begin
      if (r_state == S_SCAN) begin
        r_idx <= r_idx - 5'd1;
        if (w_cand) begin
          if (r_cnt == 3'd4) begin
            r_sh_ovf <= 1'b1;
          end else begin
            r_shadow[r_cnt[1:0]] <= {1'b1, r_idx, i_entry.id,
                                     i_entry.x, w_diff[3:0]};
            r_cnt <= r_cnt + 3'd1;
          end
        end
      end
      if (w_commit) begin
        r_active <= r_shadow;
        r_ovf    <= r_sh_ovf;
      end
    end
  end

  assign o_idx       = r_idx;
  assign o_busy      = (r_state != S_IDLE);
  assign o_slots     = r_active;
  assign o_overflow  = r_ovf;
  assign o_ovf_event = w_commit && r_sh_ovf;

endmodule

// File: rtl/sprite_hit_encoder.sv
// Per-pixel sprite hit producer: Avalon-MM sprite table + status counter,
// line scanner, and four parallel pixel comparators producing hit words.
// Ports: Avalon slave (address/write/writedata/read/readdata), line and
// pixel strobes, h0_out..h3_out hit words, hit_valid, scan_busy,
// line_overflow.
module sprite_hit_encoder
  import vpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic             read,
  output logic [31:0]      readdata,
  input  logic             new_line,
  input  logic [9:0]       line_y,
  input  logic             new_pixel,
  input  logic [9:0]       pixel_x,
  output logic [HIT_W-1:0] h0_out,
  output logic [HIT_W-1:0] h1_out,
  output logic [HIT_W-1:0] h2_out,
  output logic [HIT_W-1:0] h3_out,
  output logic             hit_valid,
  output logic             scan_busy,
  output logic             line_overflow
);

  entry_t                       r_tab [NUM_LEVELS];
  logic [15:0]                  r_ovf_cnt;
  logic [SLOTS-1:0][HIT_W-1:0]  r_h;
  logic                         r_hit_valid;
  logic [31:0]                  r_readdata;
  logic                         w_tab_sel;
  logic                         w_sts_sel;
  logic [4:0]                   w_idx;
  entry_t                       w_entry;
  slot_t [SLOTS-1:0]            w_slots;
  logic                         w_ovf_event;
  logic [SLOTS-1:0][9:0]        w_dx;
  logic [SLOTS-1:0][HIT_W-1:0]  w_word;
  logic                         w_unused;

  assign w_unused  = ^writedata[31:30];
  assign w_tab_sel = (address[7:5] == 3'd0);
  assign w_sts_sel = (address == ADDR_STATUS);
  assign w_entry   = r_tab[w_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LEVELS; i++) r_tab[i] <= '0;
    end else if (write && w_tab_sel) begin
      r_tab[address[4:0]] <= writedata[ENT_W-1:0];
    end
  end

  // Status write clears; otherwise count overflowing commits, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf_cnt <= '0;
    end else if (write && w_sts_sel) begin
      r_ovf_cnt <= '0;
    end else if (w_ovf_event && (r_ovf_cnt != 16'hFFFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  // Registered read sees pre-write state for a same-cycle write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_readdata <= '0;
    end else if (read) begin
      unique case (1'b1)
        w_tab_sel: r_readdata <= {2'b00, r_tab[address[4:0]]};
        w_sts_sel: r_readdata <= {16'h0000, r_ovf_cnt};
        default:   r_readdata <= '0;
      endcase
    end
  end

  sprite_line_scanner u_scan (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_new_line  (new_line),
    .i_line_y    (line_y),
    .i_entry     (w_entry),
    .o_idx       (w_idx),
    .o_busy      (scan_busy),
    .o_slots     (w_slots),
    .o_overflow  (line_overflow),
    .o_ovf_event (w_ovf_event)
  );

  always_comb begin
    for (int k = 0; k < SLOTS; k++) begin
      w_dx[k]   = pixel_x - w_slots[k].x;
      w_word[k] = '0;
      if (w_slots[k].vld && (w_dx[k][9:4] == 6'd0)) begin
        w_word[k] = hit_pack(w_slots[k].lvl, w_slots[k].id,
                             w_dx[k][3:0], w_slots[k].row);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h         <= '0;
      r_hit_valid <= 1'b0;
    end else begin
      r_hit_valid <= new_pixel;
      if (new_pixel) r_h <= w_word;
    end
  end

  assign h0_out    = r_h[0];
  assign h1_out    = r_h[1];
  assign h2_out    = r_h[2];
  assign h3_out    = r_h[3];
  assign hit_valid = r_hit_valid;
  assign readdata  = r_readdata;

endmodule

// File: tb/tb_sprite_hit_encoder.sv
// Self-checking bench for sprite_hit_encoder: vector table for line/pixel
// cases, scoreboard queue for hit words, hand sequences for corner cases.
module tb_sprite_hit_encoder;

  typedef logic [3:0][22:0] hits_t;

  typedef struct {
    bit         do_line;
    logic [9:0] ly;
    logic [9:0] px;
    hits_t      e;
    bit         ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  address = '0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic        read = 1'b0;
  logic [31:0] readdata;
  logic        new_line = 1'b0;
  logic [9:0]  line_y = '0;
  logic        new_pixel = 1'b0;
  logic [9:0]  pixel_x = '0;
  logic [22:0] h0_out, h1_out, h2_out, h3_out;
  logic        hit_valid, scan_busy, line_overflow;

  int    checks = 0;
  int    failures = 0;
  hits_t sb[$];
  vec_t  v[12];

  sprite_hit_encoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .address       (address),
    .write         (write),
    .writedata     (writedata),
    .read          (read),
    .readdata      (readdata),
    .new_line      (new_line),
    .line_y        (line_y),
    .new_pixel     (new_pixel),
    .pixel_x       (pixel_x),
    .h0_out        (h0_out),
    .h1_out        (h1_out),
    .h2_out        (h2_out),
    .h3_out        (h3_out),
    .hit_valid     (hit_valid),
    .scan_busy     (scan_busy),
    .line_overflow (line_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [22:0] hw(int lvl, int id, int ox, int oy);
    return {lvl[4:0], id[8:0], ox[3:0], oy[3:0], 1'b1};
  endfunction

  function automatic logic [31:0] ent(int en, int x, int y, int id);
    return {2'b00, en[0], x[9:0], y[9:0], id[8:0]};
  endfunction

  function automatic hits_t mkh(logic [22:0] a, logic [22:0] b,
                                logic [22:0] c, logic [22:0] d);
    hits_t h;
    h[0] = a; h[1] = b; h[2] = c; h[3] = d;
    return h;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    hits_t e;
    if (rst_n && hit_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_hit_valid actual=1 required=0");
      end else begin
        e = sb.pop_front();
        chk("h0_out", {9'd0, h0_out}, {9'd0, e[0]});
        chk("h1_out", {9'd0, h1_out}, {9'd0, e[1]});
        chk("h2_out", {9'd0, h2_out}, {9'd0, e[2]});
        chk("h3_out", {9'd0, h3_out}, {9'd0, e[3]});
      end
    end
  end

  task automatic wr(logic [7:0] a, logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic rd(logic [7:0] a, logic [31:0] exp, string nm);
    address = a; read = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
    chk(nm, readdata, exp);
  endtask

  task automatic pix(logic [9:0] px, hits_t e);
    sb.push_back(e);
    pixel_x = px; new_pixel = 1'b1;
    @(posedge clk); #1;
    new_pixel = 1'b0;
  endtask

  task automatic wait_scan(string nm);
    int n;
    n = 0;
    while (scan_busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, n, 33);
  endtask

  task automatic do_line(logic [9:0] y, bit ovf);
    line_y = y; new_line = 1'b1;
    @(posedge clk); #1;
    new_line = 1'b0;
    wait_scan("scan_latency");
    chk("line_overflow", {31'd0, line_overflow}, {31'd0, ovf});
  endtask

  task automatic run_vecs(int lo, int hi);
    for (int i = lo; i <= hi; i++) begin
      if (v[i].do_line) do_line(v[i].ly, v[i].ovf);
      pix(v[i].px, v[i].e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    hits_t z;
    hits_t old1, old2;
    z = '0;
    v[0]  = '{1, 53,  105, mkh(hw(10,7,5,3), 0, 0, 0), 0};
    v[1]  = '{0, 0,   115, mkh(hw(10,7,15,3), 0, 0, 0), 0};
    v[2]  = '{0, 0,   116, z, 0};
    v[3]  = '{0, 0,   99,  z, 0};
    v[4]  = '{0, 0,   100, mkh(hw(10,7,0,3), 0, 0, 0), 0};
    v[5]  = '{1, 66,  105, z, 0};
    v[6]  = '{1, 65,  100, mkh(hw(10,7,0,15), 0, 0, 0), 0};
    v[7]  = '{1, 49,  100, z, 0};
    v[8]  = '{1, 0,   2,   mkh(hw(9,29,2,0), hw(7,27,2,0),
                               hw(5,25,2,0), hw(3,23,2,0)), 1};
    v[9]  = '{1, 20,  2,   z, 0};
    v[10] = '{1, 15,  15,  mkh(hw(9,29,15,15), hw(7,27,15,15),
                               hw(5,25,15,15), hw(3,23,15,15)), 1};
    v[11] = '{0, 0,   16,  z, 1};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_scan_busy", {31'd0, scan_busy}, 32'd0);
    chk("rst_line_overflow", {31'd0, line_overflow}, 32'd0);
    for (int a = 0; a <= 32; a++) rd(a[7:0], 32'd0, "rst_read");
    pix(10'd0, z);

    wr(8'd10, ent(1, 100, 50, 7));
    rd(8'd10, ent(1, 100, 50, 7), "read_entry10");
    run_vecs(0, 7);

    wr(8'd10, 32'd0);
    for (int l = 1; l <= 9; l += 2) wr(l[7:0], ent(1, 0, 0, 20 + l));
    run_vecs(8, 8);
    rd(8'd32, 32'd1, "status_after_ovf");
    wr(8'd32, 32'd0);
    rd(8'd32, 32'd0, "status_cleared");
    run_vecs(9, 11);
    rd(8'd32, 32'd1, "status_second_ovf");
    rd(8'd40, 32'd0, "read_unmapped");

    // restart mid-scan; active set stays on line 15 until the new commit
    wr(8'd12, ent(1, 300, 200, 100));
    old1 = mkh(hw(9,29,1,15), hw(7,27,1,15), hw(5,25,1,15), hw(3,23,1,15));
    old2 = mkh(hw(9,29,2,15), hw(7,27,2,15), hw(5,25,2,15), hw(3,23,2,15));
    line_y = 10'd5; new_line = 1'b1;
    @(posedge clk); #1;
    new_line = 1'b0;
    repeat (13) begin @(posedge clk); #1; end
    pix(10'd1, old1);
    chk("busy_mid_scan", {31'd0, scan_busy}, 32'd1);
    sb.push_back(old2);
    line_y = 10'd203; new_line = 1'b1;
    pixel_x = 10'd2; new_pixel = 1'b1;
    @(posedge clk); #1;
    new_line = 1'b0; new_pixel = 1'b0;
    wait_scan("restart_latency");
    chk("restart_overflow", {31'd0, line_overflow}, 32'd0);
    pix(10'd300, mkh(hw(12,100,0,3), 0, 0, 0));
    pix(10'd2, z);

    // wrap-around and id 0
    for (int l = 1; l <= 9; l += 2) wr(l[7:0], 32'd0);
    wr(8'd12, 32'd0);
    wr(8'd20, ent(1, 1020, 1020, 55));
    wr(8'd25, ent(1, 0, 0, 0));
    address = 8'd30; writedata = ent(1, 0, 900, 0);
    write = 1'b1; read = 1'b1;
    @(posedge clk); #1;
    write = 1'b0; read = 1'b0;
    chk("rw_same_cycle_old", readdata, 32'd0);
    rd(8'd30, ent(1, 0, 900, 0), "rw_new_value");
    do_line(10'd3, 1'b0);
    pix(10'd1019, z);
    pix(10'd11, mkh(hw(20,55,15,7), 0, 0, 0));
    pix(10'd12, z);
    pix(10'd3, mkh(hw(20,55,7,7), 0, 0, 0));

    // reset during scan
    rd(8'd20, ent(1, 1020, 1020, 55), "read_before_reset");
    line_y = 10'd3; new_line = 1'b1;
    @(posedge clk); #1;
    new_line = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("busy_before_reset", {31'd0, scan_busy}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("reset_scan_busy", {31'd0, scan_busy}, 32'd0);
    chk("reset_hit_valid", {31'd0, hit_valid}, 32'd0);
    chk("reset_h0", {9'd0, h0_out}, 32'd0);
    chk("reset_h_any", {9'd0, h1_out | h2_out | h3_out}, 32'd0);
    chk("reset_readdata", readdata, 32'd0);
    chk("reset_overflow", {31'd0, line_overflow}, 32'd0);
    rst_n = 1'b1;
    rd(8'd20, 32'd0, "table_after_reset");
    rd(8'd32, 32'd0, "status_after_reset");
    pix(10'd3, z);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
